// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared sideband symbols, state/error enums and CRC-16 step
// Contents: DLE/STX/ETX symbols, err_code_e, byte_state_e, CRC constants,
//           crc16_step(crc, byte) also used by the sideband transmitter.
package sb_pkg;

  localparam logic [7:0]  DLE       = 8'hFE;
  localparam logic [7:0]  STX       = 8'h02;
  localparam logic [7:0]  ETX       = 8'h40;
  localparam logic [15:0] CRC_POLY  = 16'h8005;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;

  typedef enum logic [1:0] {
    ERR_CRC     = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_FRAMING = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    BS_IDLE,
    BS_GOT_DLE,
    BS_PAYLOAD,
    BS_PAY_DLE,
    BS_DRAIN
  } byte_state_e;

  // Non-reflected CRC-16, message bits fed MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_uart_rx.sv
// rtl/sb_uart_rx.sv - sideband line deserializer (start 0, 8 data LSB-first, stop 1)
// Ports: sb_clk, rst (sync, active-high), sbrx (serial line, idle high)
//        byte_o   received character, valid while byte_stb is high
//        byte_stb one-cycle strobe, the cycle after a good stop-bit sample
//        stop_err one-cycle pulse, the cycle after a stop bit sampled 0
module sb_uart_rx (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic [7:0] byte_o,
  output logic       byte_stb,
  output logic       stop_err
);

  logic       r_prev;
  logic       r_active;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_stb;
  logic       r_err;

  // r_prev resets to 0, so a start edge needs the line seen high first.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      r_prev   <= 1'b0;
      r_active <= 1'b0;
      r_cnt    <= 4'd0;
      r_shift  <= 8'd0;
      r_stb    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_prev <= sbrx;
      r_stb  <= 1'b0;
      r_err  <= 1'b0;
      if (!r_active) begin
        if (r_prev && !sbrx) begin
          r_active <= 1'b1;
          r_cnt    <= 4'd0;
        end
      end else if (r_cnt != 4'd8) begin
        r_shift <= {sbrx, r_shift[7:1]};
        r_cnt   <= r_cnt + 4'd1;
      end else begin
        // Stop bit; the shift register stays intact until the next
        // character's first data bit, so it doubles as the output byte.
        r_active <= 1'b0;
        if (sbrx) r_stb <= 1'b1;
        else      r_err <= 1'b1;
      end
    end
  end

  assign byte_o   = r_shift;
  assign byte_stb = r_stb;
  assign stop_err = r_err;

endmodule

// File: rtl/sb_rx_frame_parser.sv
// rtl/sb_rx_frame_parser.sv - sideband receive parser: DLE de-stuffing, CRC-16 check, payload drain
// Params: MAX_LEN maximum payload bytes per transaction (CRC excluded)
// Ports:  sb_clk, rst (sync, active-high), sbrx serial line
//         rx_data/rx_valid/rx_ready/rx_last payload byte stream
//         frame_done good transaction buffered, frame_err/err_code transaction discarded
//         busy parser not idle or buffer draining
import sb_pkg::*;

module sb_rx_frame_parser #(
  parameter int MAX_LEN = 16
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int DEPTH = MAX_LEN + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(MAX_LEN + 3) + 1;
  localparam logic [CW-1:0] LEN_LIM = CW'(DEPTH);
  localparam logic [CW-1:0] LEN_MIN = CW'(3);
  localparam logic [15:0]   CRC_AFTER_STX = crc16_step(CRC_INIT, STX);

  logic [7:0] w_byte;
  logic       w_stb;
  logic       w_stop_err;

  sb_uart_rx u_uart (
    .sb_clk   (sb_clk),
    .rst      (rst),
    .sbrx     (sbrx),
    .byte_o   (w_byte),
    .byte_stb (w_stb),
    .stop_err (w_stop_err)
  );

  byte_state_e r_state;
  logic [15:0] r_crc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd;
  logic [CW-1:0] r_last_idx;
  logic [7:0]  r_buf [DEPTH];
  logic        r_drop_dle;
  logic        r_rx_valid;
  logic        r_rx_last;
  logic [7:0]  r_rx_data;
  logic        r_done;
  logic        r_err;
  err_code_e   r_err_code;

  logic          w_is_dle;
  logic          w_wr_en;
  logic [CW-1:0] w_rd_nxt;
  logic [CW-1:0] w_count_inc;

  assign w_is_dle    = (w_byte == DLE);
  assign w_rd_nxt    = r_rd + CW'(1);
  // Count saturates so an oversized frame still reports a length error.
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CW'(1);
  assign w_wr_en     = w_stb && (r_count < LEN_LIM) &&
                       ((r_state == BS_PAYLOAD && !w_is_dle) ||
                        (r_state == BS_PAY_DLE &&  w_is_dle));

  always_ff @(posedge sb_clk) begin
    if (w_wr_en) r_buf[r_count[AW-1:0]] <= w_byte;
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      r_state    <= BS_IDLE;
      r_crc      <= CRC_INIT;
      r_count    <= '0;
      r_rd       <= '0;
      r_last_idx <= '0;
      r_drop_dle <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_last  <= 1'b0;
      r_rx_data  <= 8'h00;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_CRC;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == BS_DRAIN) begin
        if (r_rx_valid && rx_ready) begin
          if (r_rd == r_last_idx) begin
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_state    <= BS_IDLE;
          end else begin
            r_rd      <= w_rd_nxt;
            r_rx_data <= r_buf[w_rd_nxt[AW-1:0]];
            r_rx_last <= (w_rd_nxt == r_last_idx);
          end
        end
        // Dropped characters are still tracked for DLE-STX; a stuffed
        // DLE pair cancels so payload 0xFE 0x02 is not a frame start.
        if (w_stb) begin
          r_drop_dle <= w_is_dle && !r_drop_dle;
          if (r_drop_dle && w_byte == STX) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_OVERRUN;
          end
        end
      end else if (w_stop_err) begin
        if (r_state == BS_PAYLOAD || r_state == BS_PAY_DLE) begin
          r_err      <= 1'b1;
          r_err_code <= ERR_FRAMING;
        end
        r_state <= BS_IDLE;
      end else if (w_stb) begin
        case (r_state)
          BS_IDLE: if (w_is_dle) r_state <= BS_GOT_DLE;
          BS_GOT_DLE: begin
            if (w_byte == STX) begin
              r_state <= BS_PAYLOAD;
              r_crc   <= CRC_AFTER_STX;
              r_count <= '0;
            end else if (!w_is_dle) begin
              r_state <= BS_IDLE;
            end
          end
          BS_PAYLOAD: begin
            if (w_is_dle) begin
              r_state <= BS_PAY_DLE;
            end else begin
              r_crc   <= crc16_step(r_crc, w_byte);
              r_count <= w_count_inc;
            end
          end
          BS_PAY_DLE: begin
            if (w_is_dle) begin
              r_crc   <= crc16_step(r_crc, w_byte);
              r_count <= w_count_inc;
              r_state <= BS_PAYLOAD;
            end else if (w_byte == ETX) begin
              if (r_count < LEN_MIN || r_count > LEN_LIM) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_LEN;
                r_state    <= BS_IDLE;
              end else if (r_crc != 16'h0000) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_CRC;
                r_state    <= BS_IDLE;
              end else begin
                r_state    <= BS_DRAIN;
                r_done     <= 1'b1;
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_buf[0];
                r_rx_last  <= (r_count == LEN_MIN);
                r_rd       <= '0;
                r_last_idx <= r_count - LEN_MIN;
                r_drop_dle <= 1'b0;
              end
            end else if (w_byte == STX) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_FRAMING;
              r_state    <= BS_PAYLOAD;
              r_crc      <= CRC_AFTER_STX;
              r_count    <= '0;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_FRAMING;
              r_state    <= BS_IDLE;
            end
          end
          default: r_state <= BS_IDLE;
        endcase
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_last    = r_rx_last;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign err_code   = r_err_code;
  assign busy       = (r_state != BS_IDLE);

endmodule

// File: tb/tb_sb_rx_frame_parser.sv
// tb/tb_sb_rx_frame_parser.sv - self-checking bench for sb_rx_frame_parser
module tb_sb_rx_frame_parser;

  localparam int MAX_LEN = 16;
  typedef logic [7:0] bq_t[$];

  logic       sb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       sbrx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last, frame_done, frame_err, busy;
  logic [1:0] err_code;

  always #5 sb_clk = ~sb_clk;

  sb_rx_frame_parser #(.MAX_LEN(MAX_LEN)) dut (
    .sb_clk(sb_clk), .rst(rst), .sbrx(sbrx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_last(rx_last), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_evt[$];          // 4 = frame_done, 0..3 = expected err_code
  logic [8:0] exp_bytes[$]; // {last, data}
  logic [7:0] got_q[$];
  int last_err = -1;
  int ready_mode = 0;
  int pat_idx = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input bq_t q);
    logic [15:0] c;
    logic top;
    c = 16'hFFFF;
    foreach (q[k]) begin
      for (int i = 7; i >= 0; i--) begin
        top = c[15] ^ q[k][i];
        c = {c[14:0], 1'b0} ^ (top ? 16'h8005 : 16'h0000);
      end
    end
    return c;
  endfunction

  // De-stuffed stream: payload followed by CRC(STX+payload) high, low ^ lo_xor.
  function automatic bq_t build(input bq_t p, input logic [7:0] lo_xor);
    bq_t d;
    bq_t body;
    logic [15:0] c;
    body = p;
    body.push_front(8'h02);
    c = model_crc(body);
    d = p;
    d.push_back(c[15:8]);
    d.push_back(c[7:0] ^ lo_xor);
    return d;
  endfunction

  always @(posedge sb_clk) begin
    #1;
    case (ready_mode)
      0: rx_ready = 1'b1;
      1: rx_ready = 1'($urandom_range(0, 1));
      2: begin rx_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
      default: rx_ready = 1'b0;
    endcase
  end

  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          cmp_e;
  logic [31:0] cmp_x;

  always @(negedge sb_clk) begin
    if (rst || !chk_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {31'b0, rx_valid}, 32'd1);
        check("hold_data", {24'b0, rx_data}, {24'b0, prev_data});
      end
      if (frame_done) begin
        cmp_e = (exp_evt.size() > 0) ? exp_evt.pop_front() : -1;
        check("done_event", cmp_e, 32'd4);
        check("valid_with_done", {31'b0, rx_valid}, 32'd1);
      end
      if (frame_err) begin
        cmp_e = (exp_evt.size() > 0) ? exp_evt.pop_front() : -1;
        check("err_code", {30'b0, err_code}, cmp_e);
        last_err = int'(err_code);
      end
      if (rx_valid && rx_ready) begin
        cmp_x = (exp_bytes.size() > 0) ? {23'b0, exp_bytes.pop_front()} : 32'hFFFF_FFFF;
        check("rx_byte", {23'b0, rx_last, rx_data}, cmp_x);
        got_q.push_back(rx_data);
      end
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  task automatic drive_bit(input logic v);
    sbrx = v;
    @(posedge sb_clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] b, input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(!bad_stop);
    if (bad_stop) begin
      drive_bit(1'b1);
      drive_bit(1'b1);
    end
    sbrx = 1'b1;
  endtask

  task automatic send_frame(input bq_t d, input bit model_en);
    int n;
    bq_t body;
    n = d.size();
    if (model_en) begin
      if (n < 3 || n > MAX_LEN + 2) begin
        exp_evt.push_back(1);
      end else begin
        body.delete();
        body.push_back(8'h02);
        for (int k = 0; k < n - 2; k++) body.push_back(d[k]);
        if (model_crc(body) != {d[n-2], d[n-1]}) begin
          exp_evt.push_back(0);
        end else begin
          exp_evt.push_back(4);
          for (int k = 0; k < n - 2; k++) exp_bytes.push_back({k == n - 3, d[k]});
        end
      end
    end
    send_char(8'hFE, 1'b0);
    send_char(8'h02, 1'b0);
    foreach (d[k]) begin
      if (d[k] == 8'hFE) send_char(8'hFE, 1'b0);
      send_char(d[k], 1'b0);
    end
    send_char(8'hFE, 1'b0);
    send_char(8'h40, 1'b0);
  endtask

  task automatic wait_quiet(input string name);
    int cyc;
    cyc = 0;
    while ((exp_evt.size() != 0 || exp_bytes.size() != 0 || busy) && cyc < 3000) begin
      @(posedge sb_clk);
      #1;
      cyc++;
    end
    check({name, "_quiet"}, {31'b0, cyc < 3000}, 32'd1);
  endtask

  task automatic check_got(input string name, input bq_t lit);
    check({name, "_len"}, got_q.size(), lit.size());
    foreach (lit[i]) check({name, "_data"}, (i < got_q.size()) ? {24'b0, got_q[i]} : 32'hDEAD, {24'b0, lit[i]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p, d;
    int lat;
    logic [7:0] cv;

    // Model pin: CRC-16 (poly 8005, init FFFF) of "123456789" is AEE7.
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_pin", {16'b0, model_crc(p)}, 32'h0000_AEE7);

    repeat (3) @(posedge sb_clk);
    #1;
    check("rst_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_last", {31'b0, rx_last}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_code", {30'b0, err_code}, 32'd0);
    check("rst_data", {24'b0, rx_data}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge sb_clk);
    #1;

    // Good frame, ready held high, plus strobe-to-done latency.
    got_q.delete();
    send_frame(build('{8'h11, 8'h22, 8'h33}, 8'h00), 1'b1);
    lat = 0;
    while (lat < 20) begin
      @(negedge sb_clk);
      lat++;
      if (frame_done) break;
    end
    check("done_latency", lat, 32'd2);
    wait_quiet("good");
    check_got("good", '{8'h11, 8'h22, 8'h33});

    // Stuffing: payload FE A5 goes out as FE FE A5.
    got_q.delete();
    send_frame(build('{8'hFE, 8'hA5}, 8'h00), 1'b1);
    wait_quiet("stuff");
    check_got("stuff", '{8'hFE, 8'hA5});

    // CRC error.
    got_q.delete();
    send_frame(build('{8'h11, 8'h22, 8'h33}, 8'h01), 1'b1);
    wait_quiet("crc");
    check("crc_code", last_err, 32'd0);
    check("crc_no_data", got_q.size(), 32'd0);

    // Length errors: 17-byte payload, then a single byte.
    p.delete();
    for (int i = 0; i < 17; i++) p.push_back(8'(8'h10 + i));
    send_frame(build(p, 8'h00), 1'b1);
    wait_quiet("long");
    check("long_code", last_err, 32'd1);
    last_err = -1;
    send_frame('{8'hAA}, 1'b1);
    wait_quiet("short");
    check("short_code", last_err, 32'd1);

    // Framing: stop bit forced low on the second payload byte.
    exp_evt.push_back(2);
    send_char(8'hFE, 1'b0);
    send_char(8'h02, 1'b0);
    send_char(8'h11, 1'b0);
    send_char(8'h22, 1'b1);
    wait_quiet("framing");
    check("framing_code", last_err, 32'd2);

    // Backpressure 1,0,0,1.
    got_q.delete();
    ready_mode = 2;
    pat_idx = 0;
    send_frame(build('{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E}, 8'h00), 1'b1);
    wait_quiet("bp");
    check_got("bp", '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E});

    // Overrun: a second frame arrives while the first is held in DRAIN.
    got_q.delete();
    ready_mode = 3;
    send_frame(build('{8'h33, 8'h44, 8'h55}, 8'h00), 1'b1);
    exp_evt.push_back(3);
    send_frame(build('{8'h55, 8'h66, 8'h77}, 8'h00), 1'b0);
    repeat (5) @(posedge sb_clk);
    #1;
    check("overrun_code", last_err, 32'd3);
    ready_mode = 0;
    wait_quiet("overrun");
    check_got("overrun", '{8'h33, 8'h44, 8'h55});

    // Reset during DRAIN.
    ready_mode = 3;
    send_frame(build('{8'h01, 8'h03, 8'h05, 8'h07}, 8'h00), 1'b1);
    lat = 0;
    while (!rx_valid && lat < 50) begin
      @(posedge sb_clk);
      #1;
      lat++;
    end
    check("drain_reached", {31'b0, rx_valid}, 32'd1);
    rst = 1'b1;
    exp_evt.delete();
    exp_bytes.delete();
    @(posedge sb_clk);
    #1;
    check("mid_rst_valid", {31'b0, rx_valid}, 32'd0);
    check("mid_rst_last", {31'b0, rx_last}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, frame_done}, 32'd0);
    check("mid_rst_err", {31'b0, frame_err}, 32'd0);
    check("mid_rst_code", {30'b0, err_code}, 32'd0);
    check("mid_rst_data", {24'b0, rx_data}, 32'd0);
    rst = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge sb_clk);
    #1;

    // Randomized frames against the model.
    ready_mode = 1;
    for (int t = 0; t < 16; t++) begin
      p.delete();
      for (int i = $urandom_range(0, 18); i > 0; i--) begin
        cv = 8'($urandom);
        p.push_back(($urandom_range(0, 7) == 0) ? 8'hFE : cv);
      end
      cv = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      d = build(p, cv);
      send_frame(d, 1'b1);
      wait_quiet("rand");
    end

    ready_mode = 0;
    repeat (20) @(posedge sb_clk);
    #1;
    check("final_evt_q", exp_evt.size(), 32'd0);
    check("final_byte_q", exp_bytes.size(), 32'd0);
    check("final_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sb_rx_frame_parser.md
# sb_rx_frame_parser

Sideband receive path of the USB4 logical layer. Deserializes the `sbrx` line (one bit per `sb_clk` cycle, UART-style characters) and removes DLE stuffing. Delimits DLE-STX … DLE-ETX transactions and checks CRC-16. Buffers each good payload and releases it byte-by-byte over a valid/ready handshake to the config-space/transaction logic, as the receiving counterpart to the layer's `sbtx` transmitter.

## Interface
- `MAX_LEN`, default 16: maximum payload bytes per transaction (CRC excluded); sizes the buffer.
- `sb_clk`  in  1  sideband clock; one line bit per cycle.
- `rst`  in  1  synchronous, active-high reset.
- `sbrx`  in  1  serial sideband line; idle high.
- `rx_data`  out  8  current payload byte.
- `rx_valid`  out  1  `rx_data` valid.
- `rx_ready`  in  1  consumer accepts byte when `rx_valid && rx_ready`.
- `rx_last`  out  1  marks final payload byte of the transaction.
- `frame_done`  out  1  one-cycle pulse: good transaction buffered.
- `frame_err`  out  1  one-cycle pulse: transaction discarded.
- `err_code`  out  2  valid with `frame_err`: 0 CRC, 1 length, 2 framing, 3 overrun.
- `busy`  out  1  parser not in IDLE, or buffer draining.

## Operation
- Character format: start bit 0, 8 data bits LSB-first, stop bit 1.
  - Start is detected on the 1→0 transition of `sbrx`.
  - Stop bit sampled 0 → framing error; the transaction is aborted and the FSM returns to IDLE.
- Symbols: DLE = 0xFE, STX = 0x02, ETX = 0x40. Payload 0xFE is sent as 0xFE 0xFE.
- Byte FSM (advances only on received characters):
  - IDLE: DLE → GOT_DLE; else stay.
  - GOT_DLE: STX → PAYLOAD (CRC := 0xFFFF, fed STX, count := 0); DLE → GOT_DLE; else → IDLE.
  - PAYLOAD: DLE → PAY_DLE; else store byte, feed CRC, count++.
  - PAY_DLE:
    - DLE → store 0xFE, feed CRC, → PAYLOAD.
    - ETX → check.
    - STX → framing error, restart frame as in GOT_DLE.
    - Other → framing error, → IDLE.
  - Check at ETX, in this priority order:
    1. count < 3 or count > MAX_LEN+2 → length error.
    2. CRC remainder ≠ 0x0000 → CRC error.
    3. Otherwise → DRAIN with payload length = count−2, and `frame_done` pulses.
  - DRAIN:
    - Presents buffer[0..len−1] in order; `rx_last` is asserted with buffer[len−1].
    - After the last handshake → IDLE.
    - Characters received during DRAIN are dropped. A DLE followed by STX seen during DRAIN gives one overrun error per dropped frame start.
- The count keeps incrementing past MAX_LEN+2 without writing the buffer. It saturates and does not wrap; the length error is raised at ETX.
- CRC: polynomial 0x8005, init 0xFFFF, non-reflected, bits fed MSB-first, no final XOR.
  - Input is STX, the de-stuffed payload, then the two CRC bytes (high byte first).
  - A good frame leaves remainder 0x0000.
  - CRC bytes are written into the buffer but are never presented.

## Timing
- Values after reset:
  - Outputs: `rx_valid`, `rx_last`, `frame_done`, `frame_err`, `busy` = 0; `err_code` = 0; `rx_data` = 0x00.
  - Internal state: FSM = IDLE; CRC = 0xFFFF; count = 0.
  - The deserializer ignores `sbrx` until it has seen `sbrx` = 1 for one cycle.
- Character strobe: one cycle after the stop-bit sample. The start-bit edge to strobe is 10 cycles.
- `frame_done` / `frame_err`: registered, in the cycle after the ETX (or offending) strobe.
- First `rx_valid`: in the same cycle as `frame_done`.
- `rx_data` holds stable while `rx_valid && !rx_ready`. At one byte per cycle, a full handshake drains len bytes in len cycles.
- Reset in mid-frame or mid-drain: everything is discarded. No pulse is generated for the aborted transaction.
- A strobe and a handshake in the same cycle are both processed.

## Structure
- Shared package `sb_pkg`:
  - `DLE`, `STX`, `ETX` constants.
  - `err_code_e` enum.
  - `byte_state_e` enum.
  - `crc16_step(crc, byte)` function, reused by the sideband transmitter.
- Sub-module `sb_uart_rx`: start/stop bit deserializer.
  - Ports: `sb_clk`, `rst`, `sbrx` → `byte_o[7:0]`, `byte_stb`, `stop_err`.
- Parser, CRC, buffer (MAX_LEN+2 × 8 register file), and drain counter sit in `sb_rx_frame_parser`.

## Test plan
- Good frame: FE 02 11 22 33 + good CRC, then FE 40, `rx_ready` = 1.
  - `frame_done` pulses; `rx_data` = 11, 22, 33 on consecutive cycles; `rx_last` asserted with 33.
- Stuffing: payload FE FE A5 + CRC.
  - Delivers FE, A5 (length 2).
- CRC error: the good frame above with the CRC low byte XOR 0x01.
  - `frame_err`, `err_code` = 0; `rx_valid` never asserted.
- Length error: FE 02 + 17 payload bytes + CRC + FE 40 (MAX_LEN = 16) → `err_code` = 1.
- Length error: FE 02 AA FE 40 → `err_code` = 1.
- Framing/backpressure:
  - Stop bit forced 0 on the second payload byte → `err_code` = 2.
  - A good frame with `rx_ready` toggling 1,0,0,1 → `rx_data` holds while not ready.
  - `rst` during DRAIN → all outputs return to reset values next cycle.
- Overrun: with `rx_ready` = 0 holding DRAIN, send FE 02 … → exactly one `frame_err`, `err_code` = 3; the original payload is still delivered intact.
